sprite_compositor: RTL and testbench
====================================

// Module: sprite_compositor
// PURPOSE
// Consumer end of the bitmap drawing interface: takes drawingRequest/RGB pairs from up to
// NUM_LAYERS sprite bitmaps plus a background colour, and emits one registered VGA pixel by
// fixed priority (layer 0 on top). Also detects per-frame overlaps between layer 0 (player or
// rope) and every other layer. Each overlap yields one collision pulse per pair per frame.
// Sits between the sprite bitmaps and the VGA output stage; the game controller reads the pulses.
// PARAMETERS
// NUM_LAYERS    4      number of sprite layers, 2..8; layer 0 is highest priority
// TRANSPARENT   8'hFF  colour code never driven out by a layer
// BG_DELAY      1      pipeline stages applied to bgRGB so it lines up with the layer inputs
// PORTS
// clk             in   1             pixel clock
// resetN          in   1             asynchronous, active-low reset
// startOfFrame    in   1             one-cycle pulse at the first pixel of each frame
// layerDR         in   NUM_LAYERS    per-layer drawingRequest (already registered by the bitmaps)
// layerRGB        in   NUM_LAYERS*8  per-layer RGB332; layer i occupies bits [8i+7:8i]
// bgRGB           in   8             background colour, combinational from pixel coordinates
// RGBOut          out  8             composited pixel colour
// anyDR           out  1             at least one layer drew this pixel
// collisionPulse  out  NUM_LAYERS   bit i (i>=1) pulses when layer 0 and layer i overlap; bit 0 is tied to 0
// collisionAny    out  1             OR of all collisionPulse bits
// BEHAVIOUR
// - Reset: RGBOut=8'h00, anyDR=0, collisionPulse=0, collisionAny=0, all frame flags and BG pipe cleared.
// - bgRGB passes through BG_DELAY registers to give bgAligned. BG_DELAY=0 means a direct wire.
// - Priority: winner is the lowest i with layerDR[i]=1. If no layer is requesting, bgAligned is used.
// - RGBOut/anyDR are registered: 1 cycle after layerDR/layerRGB, 1+BG_DELAY cycles after bgRGB.
// - Overlap(i) = layerDR[0] & layerDR[i], for i in 1..NUM_LAYERS-1, evaluated combinationally each cycle.
// - Frame flag hit[i]: set on overlap(i); cleared on startOfFrame.
// - collisionPulse[i] is registered. It is 1 for exactly one cycle, the cycle after the first overlap(i)
//   in a frame. The condition is overlap(i) & ~hit[i] (after the startOfFrame clear).
// - startOfFrame and overlap(i) in the same cycle: the clear applies first, then the overlap counts
//   as the new frame's first hit. hit[i] ends up set and the pulse fires.
// - Overlaps repeated within a frame do not re-pulse. Different pairs pulse independently, and
//   several pairs may pulse in the same cycle.
// - startOfFrame with no overlap: hit cleared; collisionPulse is 0 the next cycle.
// - No startOfFrame ever: flags stay set and no further pulses occur (this is legal).
// - Reset in mid-frame: everything clears at once. The first overlap after release pulses.
// - Width rules: layerRGB is sliced as [8i+:8]. No arithmetic is performed.
//   Priority selection uses a for-loop scanning from the top index down.
// STRUCTURE
// - Shared package gfx_pkg:
//   - typedef rgb332_t (logic [7:0])
//   - localparam TRANSPARENT_RGB = 8'hFF
//   - localparam MAX_LAYERS = 8
// - One sub-module, collision_frame_latch: per-pair flag plus pulse generator, instantiated
//   NUM_LAYERS-1 times in a generate loop.
// - Top level contains: BG delay pipe, priority mux, output register.
// TESTING
// 1. Reset, then all layerDR=0, bgRGB=8'h1C -> after 1+BG_DELAY cycles RGBOut=8'h1C, anyDR=0, no pulses.
// 2. layerDR=4'b0110, layerRGB[1]=8'hE0, layerRGB[2]=8'h03 -> next cycle RGBOut=8'hE0, anyDR=1, no collision.
// 3. layerDR=4'b0101 held for 5 cycles -> collisionPulse=4'b0100 for exactly 1 cycle, then 0;
//    RGBOut equals layer 0's colour throughout.
// 4. After test 3, pulse startOfFrame, then layerDR=4'b0101 again -> pulse repeats once.
//    Repeat with startOfFrame in the same cycle as the overlap -> pulse still fires once.
// 5. layerDR=4'b1111 in one cycle -> collisionPulse=4'b1110 and collisionAny=1 for 1 cycle.
// 6. Assert resetN=0 while hit flags are set and a pulse is pending -> outputs read 0 at once.
//    After release, a new overlap pulses without any startOfFrame.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics types and constants for the sprite/VGA pipeline.
package gfx_pkg;

  // 8-bit RGB332 pixel colour.
  typedef logic [7:0] rgb332_t;

  // Colour code that bitmaps never present together with a drawing request.
  localparam rgb332_t TRANSPARENT_RGB = 8'hFF;

  // Largest number of sprite layers the compositor is built for.
  localparam int MAX_LAYERS = 8;

endpackage

// File: rtl/sprite_compositor_if.sv
// Bitmap-to-compositor bus: layer requests/colours and background in, composited pixel and
// collision pulses out. The master is the producer side (bitmaps, background, game controller).
interface sprite_compositor_if import gfx_pkg::*; #(
  parameter int NUM_LAYERS = 4
) ();

  logic                    startOfFrame;
  logic [NUM_LAYERS-1:0]   layerDR;
  logic [NUM_LAYERS*8-1:0] layerRGB;
  rgb332_t                 bgRGB;
  rgb332_t                 RGBOut;
  logic                    anyDR;
  logic [NUM_LAYERS-1:0]   collisionPulse;
  logic                    collisionAny;

  modport master (
    output startOfFrame, layerDR, layerRGB, bgRGB,
    input  RGBOut, anyDR, collisionPulse, collisionAny
  );

  modport slave (
    input  startOfFrame, layerDR, layerRGB, bgRGB,
    output RGBOut, anyDR, collisionPulse, collisionAny
  );

endinterface

// File: rtl/collision_frame_latch.sv
// Per-pair collision tracker: remembers whether the pair already overlapped this frame and
// emits a single registered pulse on the first overlap of each frame.
module collision_frame_latch (
  input  logic clk,
  input  logic resetN,
  input  logic start_of_frame,
  input  logic overlap,
  output logic pulse
);

  logic hit;
  logic hit_cleared;

  // The frame-start clear takes effect before the overlap is considered, so an overlap on the
  // first pixel of a frame counts as that frame's first hit.
  always_comb begin
    hit_cleared = hit & ~start_of_frame;
  end

  // Frame flag and one-shot pulse register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so both registers sample the same pre-edge values.
      hit   <= hit_cleared | overlap;
      pulse <= overlap & ~hit_cleared;
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: fixed-priority pixel mux over the sprite layers with a delayed background
// fallback, registered VGA pixel output, and per-frame collision pulses between layer 0 and
// every other layer.
module sprite_compositor import gfx_pkg::*; #(
  parameter int      NUM_LAYERS  = 4,
  parameter rgb332_t TRANSPARENT = TRANSPARENT_RGB,
  parameter int      BG_DELAY    = 1
) (
  input  logic               clk,
  input  logic               resetN,
  sprite_compositor_if.slave bus
);

  rgb332_t               bg_aligned;
  rgb332_t               win_rgb;
  logic                  win_dr;
  logic [NUM_LAYERS-1:0] pulse;

  // Background alignment: bgRGB is combinational from the pixel coordinates, whereas the layer
  // inputs arrive registered, so the background is delayed to match.
  if (BG_DELAY == 0) begin : g_bg_wire
    assign bg_aligned = bus.bgRGB;
  end else begin : g_bg_pipe
    rgb332_t bg_pipe [BG_DELAY];

    // Shift the background colour through BG_DELAY stages.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        // NOTE: this array is a handful of flops, not a RAM, so resetting it costs nothing special.
        for (int i = 0; i < BG_DELAY; i++) bg_pipe[i] <= '0;
      end else begin
        bg_pipe[0] <= bus.bgRGB;
        for (int i = 1; i < BG_DELAY; i++) bg_pipe[i] <= bg_pipe[i-1];
      end
    end

    assign bg_aligned = bg_pipe[BG_DELAY-1];
  end

  // Priority select: scanning from the top index down lets the lowest requesting layer win.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    win_rgb = bg_aligned;
    win_dr  = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (bus.layerDR[i]) begin
        win_rgb = bus.layerRGB[8*i +: 8];
        win_dr  = 1'b1;
      end
    end
  end

  // Registered pixel output toward the VGA stage.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.RGBOut <= '0;
      bus.anyDR  <= 1'b0;
    end else begin
      bus.RGBOut <= win_rgb;
      bus.anyDR  <= win_dr;
    end
  end

  // One frame latch per (layer 0, layer i) pair; layer 0 never collides with itself.
  assign pulse[0] = 1'b0;

  for (genvar i = 1; i < NUM_LAYERS; i++) begin : g_pair
    collision_frame_latch u_latch (
      .clk            (clk),
      .resetN         (resetN),
      .start_of_frame (bus.startOfFrame),
      .overlap        (bus.layerDR[0] & bus.layerDR[i]),
      .pulse          (pulse[i])
    );
  end

  assign bus.collisionPulse = pulse;
  assign bus.collisionAny   = |pulse;

  // Elaboration sanity and upstream contract: layer count in range, and a requesting layer
  // never presents the transparent colour.
  a_layer_range : assert property (@(posedge clk)
    (NUM_LAYERS >= 2) && (NUM_LAYERS <= MAX_LAYERS));

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_chk
    a_no_transparent : assert property (@(posedge clk) disable iff (!resetN)
      bus.layerDR[i] |-> (bus.layerRGB[8*i +: 8] != TRANSPARENT));
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: directed vectors push hand-computed expectations,
// a monitor pops and compares one entry per registered output cycle.
module tb_sprite_compositor;
  import gfx_pkg::*;

  typedef struct packed {
    rgb332_t    rgb;
    logic       any_dr;
    logic [3:0] pulse;
    logic       col_any;
  } exp_t;

  logic clk;
  logic resetN;
  int   tests;
  int   fails;
  exp_t exp_q [$];

  sprite_compositor_if #(.NUM_LAYERS(4)) bus ();

  sprite_compositor #(
    .NUM_LAYERS  (4),
    .TRANSPARENT (8'hFF),
    .BG_DELAY    (1)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector on the falling edge and queue what the outputs must show after the next
  // rising edge.
  task automatic step(input logic sof, input logic [3:0] dr, input rgb332_t bg,
                      input rgb332_t e_rgb, input logic e_any, input logic [3:0] e_pulse);
    exp_t e;
    @(negedge clk);
    bus.startOfFrame = sof;
    bus.layerDR      = dr;
    bus.bgRGB        = bg;
    e.rgb     = e_rgb;
    e.any_dr  = e_any;
    e.pulse   = e_pulse;
    e.col_any = (e_pulse != 4'b0000);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle after reset; compare against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (resetN && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("RGBOut",         bus.RGBOut,         e.rgb);
        check("anyDR",          bus.anyDR,          e.any_dr);
        check("collisionPulse", bus.collisionPulse, e.pulse);
        check("collisionAny",   bus.collisionAny,   e.col_any);
      end
    end
  end

  initial begin
    tests  = 0;
    fails  = 0;
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.layerDR      = 4'b0000;
    bus.layerRGB     = {8'h4A, 8'h03, 8'hE0, 8'h92};
    bus.bgRGB        = 8'h00;

    #12;
    check("reset RGBOut",         bus.RGBOut,         8'h00);
    check("reset anyDR",          bus.anyDR,          1'b0);
    check("reset collisionPulse", bus.collisionPulse, 4'b0000);
    check("reset collisionAny",   bus.collisionAny,   1'b0);
    @(negedge clk);
    resetN = 1'b1;

    // Test 1: background only; bgRGB shows up after 1+BG_DELAY cycles.
    step(1'b1, 4'b0000, 8'h1C, 8'h00, 1'b0, 4'b0000);
    step(1'b0, 4'b0000, 8'h1C, 8'h1C, 1'b0, 4'b0000);
    // Test 2: layers 1 and 2 requesting, layer 1 wins, no layer-0 overlap.
    step(1'b0, 4'b0110, 8'h1C, 8'hE0, 1'b1, 4'b0000);
    // Test 3: layers 0 and 2 overlap for 5 cycles -> one pulse on bit 2.
    step(1'b0, 4'b0101, 8'h1C, 8'h92, 1'b1, 4'b0100);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0101, 8'h1C, 8'h92, 1'b1, 4'b0000);
    // Test 4a: new frame with no overlap, then the overlap pulses again once.
    step(1'b1, 4'b0000, 8'h1C, 8'h1C, 1'b0, 4'b0000);
    step(1'b0, 4'b0101, 8'h1C, 8'h92, 1'b1, 4'b0100);
    step(1'b0, 4'b0101, 8'h1C, 8'h92, 1'b1, 4'b0000);
    step(1'b0, 4'b0000, 8'h1C, 8'h1C, 1'b0, 4'b0000);
    // Test 4b: startOfFrame in the same cycle as the overlap.
    step(1'b1, 4'b0101, 8'h1C, 8'h92, 1'b1, 4'b0100);
    step(1'b0, 4'b0101, 8'h1C, 8'h92, 1'b1, 4'b0000);
    // Test 5: all layers at once -> three pairs pulse together; layer 2 already hit is cleared by sof.
    step(1'b1, 4'b0000, 8'h1C, 8'h1C, 1'b0, 4'b0000);
    step(1'b0, 4'b1111, 8'h1C, 8'h92, 1'b1, 4'b1110);
    step(1'b0, 4'b1111, 8'h1C, 8'h92, 1'b1, 4'b0000);
    step(1'b0, 4'b1000, 8'h1C, 8'h4A, 1'b1, 4'b0000);
    step(1'b0, 4'b1010, 8'h1C, 8'hE0, 1'b1, 4'b0000);
    // Test 6: fire a pulse, then reset while it is high and the flags are set.
    step(1'b1, 4'b0101, 8'h1C, 8'h92, 1'b1, 4'b0100);
    @(posedge clk);
    #3;
    resetN = 1'b0;
    #1;
    check("midreset RGBOut",         bus.RGBOut,         8'h00);
    check("midreset anyDR",          bus.anyDR,          1'b0);
    check("midreset collisionPulse", bus.collisionPulse, 4'b0000);
    check("midreset collisionAny",   bus.collisionAny,   1'b0);
    bus.startOfFrame = 1'b0;
    bus.layerDR      = 4'b0000;
    @(negedge clk);
    resetN = 1'b1;
    // First overlap after release pulses without any startOfFrame, and only once.
    step(1'b0, 4'b0101, 8'h1C, 8'h92, 1'b1, 4'b0100);
    step(1'b0, 4'b0101, 8'h1C, 8'h92, 1'b1, 4'b0000);
    step(1'b0, 4'b0000, 8'h1C, 8'h1C, 1'b0, 4'b0000);

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
